// File: rtl/cp0_pkg.sv
// cp0_pkg: types and constants shared by the exception-entry slice.
// Holds the sequencer state encoding, cause codes, the default handler
// vector and a helper that isolates the highest set bit of an IRQ vector.
package cp0_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } exc_state_t;

    localparam logic [4:0]  EXC_INT            = 5'd0;
    localparam logic [4:0]  EXC_SYS            = 5'd8;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0040_0004;
    localparam int          NIRQ_MAX           = 8;

    // One-hot of the highest-index set bit of v (all zero when v is zero).
    function automatic logic [NIRQ_MAX-1:0] msb_onehot(input logic [NIRQ_MAX-1:0] v);
        logic [NIRQ_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < NIRQ_MAX; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_pending.sv
// irq_pending: interrupt capture, mask register and live cause_ip.
// With IRQ_EDGE_EN defined, pending bits latch on rising edges of irq and
// the highest-index unmasked pending bit is cleared when the interrupt is
// taken. Without it, pending simply follows the irq lines.
module irq_pending
    import cp0_pkg::*;
#(
    parameter int NIRQ = 8
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic [NIRQ-1:0] i_irq,
    input  logic            i_im_we,
    input  logic [NIRQ-1:0] i_im_wdata,
    input  logic            i_take_irq,
    output logic [NIRQ-1:0] o_cause_ip
);

    logic [NIRQ-1:0] r_im;
    logic [NIRQ-1:0] w_pending;

    // Interrupt mask register; a write only affects the take decision from the next cycle on.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_im <= '0;
        end else if (i_im_we) begin
            r_im <= i_im_wdata;
        end
    end

`ifdef IRQ_EDGE_EN
    logic [NIRQ-1:0]     r_irq_d;
    logic [NIRQ-1:0]     r_pending;
    logic [NIRQ_MAX-1:0] w_ip_ext;
    logic [NIRQ_MAX-1:0] w_clr_ext;
    logic [NIRQ-1:0]     w_clr;

    // Widen the live cause bits so the package helper can pick the top one.
    always_comb begin
        w_ip_ext            = '0;
        w_ip_ext[NIRQ-1:0]  = r_pending & r_im;
    end

    assign w_clr_ext = msb_onehot(w_ip_ext);
    assign w_clr     = i_take_irq ? w_clr_ext[NIRQ-1:0] : '0;

    // Edge capture: a fresh rising edge wins over a clear of the same bit.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_irq_d   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_d   <= i_irq;
            r_pending <= (r_pending & ~w_clr) | (i_irq & ~r_irq_d);
        end
    end

    assign w_pending = r_pending;
`else
    logic w_unused_take;

    assign w_unused_take = i_take_irq;
    assign w_pending     = i_irq;
`endif

    assign o_cause_ip = w_pending & r_im;

endmodule

// File: rtl/exception_entry.sv
// exception_entry: exception entry/return sequencer for the single-cycle
// MIPS core. Takes enabled interrupts and syscalls in RUN, captures EPC and
// cause, raises EXL, strobes exc_req for one cycle, then waits in HANDLER
// for eret and strobes ret_req for one cycle on the way back to RUN.
// Build option: define IRQ_EDGE_EN for edge-latched interrupt pending bits;
// the default build uses level-sensitive interrupt lines.
module exception_entry
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
    parameter int          NIRQ       = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NIRQ-1:0] irq,
    input  logic            ie,
    input  logic            im_we,
    input  logic [NIRQ-1:0] im_wdata,
    input  logic            syscall,
    input  logic            eret,
    input  logic [31:0]     pc_next,
    output logic            exc_req,
    output logic [31:0]     exc_vector,
    output logic            ret_req,
    output logic [31:0]     epc,
    output logic            exl,
    output logic [4:0]      cause_code,
    output logic [NIRQ-1:0] cause_ip,
    output logic            nest_err
);

    exc_state_t r_state;
    logic       r_defer_sys;
    logic       w_in_run;
    logic       w_sys_want;
    logic       w_irq_want;
    logic       w_take;
    logic       w_take_irq;

    irq_pending #(
        .NIRQ (NIRQ)
    ) u_irq_pending (
        .i_clock    (clock),
        .i_reset_n  (reset_n),
        .i_irq      (irq),
        .i_im_we    (im_we),
        .i_im_wdata (im_wdata),
        .i_take_irq (w_take_irq),
        .o_cause_ip (cause_ip)
    );

    // A syscall that arrived during RETURN is replayed here so it is not lost.
    assign w_in_run   = (r_state == ST_RUN);
    assign w_sys_want = syscall | r_defer_sys;
    assign w_irq_want = ie & (|cause_ip);
    assign w_take     = w_in_run & (w_sys_want | w_irq_want);
    assign w_take_irq = w_in_run & ~w_sys_want & w_irq_want;
    assign exc_vector = EXC_VECTOR;

    // Sequencer FSM with registered strobes and captured EPC/cause/EXL.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_defer_sys <= 1'b0;
            epc         <= '0;
            exl         <= 1'b0;
            cause_code  <= EXC_INT;
            nest_err    <= 1'b0;
            exc_req     <= 1'b0;
            ret_req     <= 1'b0;
        end else begin
            if (syscall && exl) begin
                nest_err <= 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_take) begin
                        r_state     <= ST_ENTER;
                        r_defer_sys <= 1'b0;
                        epc         <= pc_next;
                        exl         <= 1'b1;
                        cause_code  <= w_sys_want ? EXC_SYS : EXC_INT;
                        exc_req     <= 1'b1;
                    end
                end
                ST_ENTER: begin
                    exc_req <= 1'b0;
                    r_state <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    if (eret) begin
                        r_state <= ST_RETURN;
                        exl     <= 1'b0;
                        ret_req <= 1'b1;
                    end
                end
                ST_RETURN: begin
                    ret_req <= 1'b0;
                    r_state <= ST_RUN;
                    if (syscall) begin
                        r_defer_sys <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_entry.sv
// tb_exception_entry: directed and randomized checks of exception_entry
// against a behavioural model of the entry/return rules.
module tb_exception_entry;

   logic        clock;
   logic        reset_n;
   logic [7:0]  irq;
   logic        ie;
   logic        im_we;
   logic [7:0]  im_wdata;
   logic        syscall;
   logic        eret;
   logic [31:0] pc_next;
   logic        exc_req;
   logic [31:0] exc_vector;
   logic        ret_req;
   logic [31:0] epc;
   logic        exl;
   logic [4:0]  cause_code;
   logic [7:0]  cause_ip;
   logic        nest_err;

   int checks;
   int failures;

   // Behavioural model: the sequencer phase is implied by the strobes and EXL
   // (RUN = no EXL and no return strobe, ENTER = EXL with entry strobe, ...).
   bit        mExcReq;
   bit        mRetReq;
   bit        mExl;
   bit        mNest;
   bit        mDefer;
   bit [31:0] mEpc;
   bit [4:0]  mCause;
   bit [7:0]  mIm;
   bit [7:0]  mPend;
   bit [7:0]  mIrqPrev;
   bit [7:0]  mLive;
   bit [7:0]  mClr;
   bit        mWantSys;
   bit        mWantInt;

   exception_entry #(
      .EXC_VECTOR (32'h0040_0004),
      .NIRQ       (8)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .irq        (irq),
      .ie         (ie),
      .im_we      (im_we),
      .im_wdata   (im_wdata),
      .syscall    (syscall),
      .eret       (eret),
      .pc_next    (pc_next),
      .exc_req    (exc_req),
      .exc_vector (exc_vector),
      .ret_req    (ret_req),
      .epc        (epc),
      .exl        (exl),
      .cause_code (cause_code),
      .cause_ip   (cause_ip),
      .nest_err   (nest_err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Inputs change 2 time units after a rising edge and are sampled by the next one.
   task automatic applyStimulus(input logic s, input logic e, input logic [7:0] iq, input logic ieV,
                                input logic we, input logic [7:0] wd, input logic [31:0] pc);
      @(posedge clock);
      #2;
      syscall  = s;
      eret     = e;
      irq      = iq;
      ie       = ieV;
      im_we    = we;
      im_wdata = wd;
      pc_next  = pc;
   endtask

   task automatic pulseReset();
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      @(posedge clock);
      #2;
      reset_n = 1'b1;
   endtask

   // Model advances on every rising edge from the inputs the DUT also samples.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mExcReq  = 1'b0;
         mRetReq  = 1'b0;
         mExl     = 1'b0;
         mNest    = 1'b0;
         mDefer   = 1'b0;
         mEpc     = 32'h0;
         mCause   = 5'd0;
         mIm      = 8'h00;
         mPend    = 8'h00;
         mIrqPrev = 8'h00;
      end else begin
`ifdef IRQ_EDGE_EN
         mLive = mPend & mIm;
`else
         mLive = irq & mIm;
`endif
         mWantSys = syscall || mDefer;
         mWantInt = ie && (mLive != 8'h00);
         mClr     = 8'h00;
         if (syscall && mExl) mNest = 1'b1;
         if (!mExl && !mRetReq) begin
            if (mWantSys || mWantInt) begin
               mEpc    = pc_next;
               mExl    = 1'b1;
               mExcReq = 1'b1;
               mDefer  = 1'b0;
               mCause  = mWantSys ? 5'd8 : 5'd0;
               if (!mWantSys) begin
                  for (int i = 7; i >= 0; i--) begin
                     if (mLive[i] && mClr == 8'h00) mClr[i] = 1'b1;
                  end
               end
            end
         end else if (mExcReq) begin
            mExcReq = 1'b0;
         end else if (mRetReq) begin
            mRetReq = 1'b0;
            if (syscall) mDefer = 1'b1;
         end else if (eret) begin
            mExl    = 1'b0;
            mRetReq = 1'b1;
         end
         mPend    = (mPend & ~mClr) | (irq & ~mIrqPrev);
         mIrqPrev = irq;
         if (im_we) mIm = im_wdata;
      end
   end

   // Compare every output against the model in the middle of each cycle.
   always @(negedge clock) begin
      if (reset_n) begin
         checkOutput("exc_req", {31'h0, exc_req}, {31'h0, mExcReq});
         checkOutput("ret_req", {31'h0, ret_req}, {31'h0, mRetReq});
         checkOutput("exl", {31'h0, exl}, {31'h0, mExl});
         checkOutput("epc", epc, mEpc);
         checkOutput("cause_code", {27'h0, cause_code}, {27'h0, mCause});
         checkOutput("nest_err", {31'h0, nest_err}, {31'h0, mNest});
`ifdef IRQ_EDGE_EN
         checkOutput("cause_ip", {24'h0, cause_ip}, {24'h0, mPend & mIm});
`else
         checkOutput("cause_ip", {24'h0, cause_ip}, {24'h0, irq & mIm});
`endif
         checkOutput("exc_vector", exc_vector, 32'h0040_0004);
      end
   end

   // Directed scenarios with literal expectations, then a randomized run.
   initial begin
      logic [7:0] irqR;
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      irq      = 8'hFF;
      ie       = 1'b0;
      im_we    = 1'b0;
      im_wdata = 8'h00;
      syscall  = 1'b0;
      eret     = 1'b0;
      pc_next  = 32'h0;
      irqR     = 8'h00;

      #12;
      checkOutput("rst_exc_req", {31'h0, exc_req}, 32'h0);
      checkOutput("rst_ret_req", {31'h0, ret_req}, 32'h0);
      checkOutput("rst_exl", {31'h0, exl}, 32'h0);
      checkOutput("rst_epc", epc, 32'h0);
      checkOutput("rst_cause", {27'h0, cause_code}, 32'h0);
      checkOutput("rst_nest", {31'h0, nest_err}, 32'h0);
      checkOutput("rst_cause_ip", {24'h0, cause_ip}, 32'h0);

      @(posedge clock);
      #2;
      reset_n = 1'b1;
      irq     = 8'h00;
      ie      = 1'b1;

      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 32'h0040_0000);
         @(negedge clock);
         checkOutput("no_take_im0", {31'h0, exc_req}, 32'h0);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      pulseReset();

      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 8'h00, 32'h0040_0010);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0040_0020);
      @(negedge clock);
      checkOutput("int_exc_req", {31'h0, exc_req}, 32'h1);
      checkOutput("int_epc", epc, 32'h0040_0010);
      checkOutput("int_exl", {31'h0, exl}, 32'h1);
      checkOutput("int_cause", {27'h0, cause_code}, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("int_strobe_once", {31'h0, exc_req}, 32'h0);

      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("ret_req", {31'h0, ret_req}, 32'h1);
      checkOutput("ret_exl", {31'h0, exl}, 32'h0);
      checkOutput("ret_epc", epc, 32'h0040_0010);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("ret_strobe_once", {31'h0, ret_req}, 32'h0);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("eret_in_run", {31'h0, ret_req}, 32'h0);

      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 32'h0);
      applyStimulus(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 32'h0040_0100);
      applyStimulus(1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("prio_exc_req", {31'h0, exc_req}, 32'h1);
      checkOutput("prio_cause_sys", {27'h0, cause_code}, 32'h8);
      checkOutput("prio_epc", epc, 32'h0040_0100);
      applyStimulus(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 32'h0040_0104);
      @(negedge clock);
      checkOutput("prio_ret_req", {31'h0, ret_req}, 32'h1);
      applyStimulus(1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 32'h0040_0104);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("prio_int_exc_req", {31'h0, exc_req}, 32'h1);
      checkOutput("prio_int_cause", {27'h0, cause_code}, 32'h0);
      checkOutput("prio_int_epc", epc, 32'h0040_0104);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);

      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0040_0200);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("nest_first_entry", {31'h0, exc_req}, 32'h1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0040_0300);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("nest_no_exc_req", {31'h0, exc_req}, 32'h0);
      checkOutput("nest_epc", epc, 32'h0040_0200);
      checkOutput("nest_err_set", {31'h0, nest_err}, 32'h1);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("nest_err_sticky", {31'h0, nest_err}, 32'h1);
      checkOutput("nest_exl_clear", {31'h0, exl}, 32'h0);
      pulseReset();
      @(negedge clock);
      checkOutput("nest_err_reset", {31'h0, nest_err}, 32'h0);

      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
`ifdef IRQ_EDGE_EN
      checkOutput("pulse_latched", {24'h0, cause_ip}, 32'h20);
`else
      checkOutput("pulse_level", {24'h0, cause_ip}, 32'h0);
`endif
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0040_0500);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
`ifdef IRQ_EDGE_EN
      checkOutput("pulse_taken", {31'h0, exc_req}, 32'h1);
      checkOutput("pulse_bit_cleared", {24'h0, cause_ip}, 32'h0);
`else
      checkOutput("pulse_lost", {31'h0, exc_req}, 32'h0);
`endif
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);

      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0040_0400);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("mid_enter_strobe", {31'h0, exc_req}, 32'h1);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("mid_enter_drop", {31'h0, exc_req}, 32'h0);
      checkOutput("mid_enter_exl", {31'h0, exl}, 32'h0);
      checkOutput("mid_enter_epc", epc, 32'h0);
      @(posedge clock);
      #2;
      reset_n = 1'b1;

      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 3) == 0) irqR = 8'($urandom);
         applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, irqR,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                       8'($urandom), $urandom & 32'hFFFF_FFFC);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exception_entry.md
# exception_entry

Exception-entry and return sequencer for the single-cycle MIPS core, sitting between the interrupt sources and the CP0 register file. It detects enabled interrupts and `syscall` requests, captures EPC and the cause, and sets EXL. It issues a one-cycle PC redirect to the exception vector, and issues the matching return redirect when `eret` executes inside a handler. It drives the exception-entry direction of the CP0 protocol; CP0 owns the `eret`/`mtc0`/`mfc0` register side.

## Interface
- `EXC_VECTOR`, default 32'h0040_0004: handler entry address.
- `NIRQ`, default 8: number of interrupt lines, at most 8.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `irq`  in  NIRQ  external interrupt lines.
- `ie`  in  1  global interrupt enable (CP0 Status[0], driven by `di`/`ei`).
- `im_we`  in  1  write strobe for the interrupt mask.
- `im_wdata`  in  NIRQ  new mask value.
- `syscall`  in  1  high for the cycle a `syscall` instruction executes.
- `eret`  in  1  high for the cycle an `eret` instruction executes.
- `pc_next`  in  32  address of the next instruction the core would execute.
- `exc_req`  out  1  one-cycle redirect strobe to `exc_vector`.
- `exc_vector`  out  32  constant `EXC_VECTOR`.
- `ret_req`  out  1  one-cycle redirect strobe to `epc`.
- `epc`  out  32  saved return address.
- `exl`  out  1  exception level; high while in a handler.
- `cause_code`  out  5  0 = interrupt, 8 = syscall.
- `cause_ip`  out  NIRQ  pending, unmasked interrupt bits (live).
- `nest_err`  out  1  sticky; set on any `syscall` seen while `exl` is high.

## Operation
- States: RUN, ENTER, HANDLER, RETURN.
- Reset values: state RUN, `epc` 0, `exl` 0, `cause_code` 0, `im` 0, pending 0, `nest_err` 0, `exc_req` 0, `ret_req` 0.
- `im` register: `im_we` loads `im_wdata`. The write is visible to the take decision starting the following cycle.
- Take condition, evaluated in RUN:
  - `syscall`; or
  - `ie && |(pending & im)`.
- Priority when both hold: `syscall` wins; the interrupt stays pending.
- On take:
  - state moves to ENTER;
  - `epc` <= `pc_next`;
  - `exl` <= 1;
  - `cause_code` <= 8 for `syscall`, 0 for an interrupt.
- ENTER lasts exactly one cycle with `exc_req`=1, then moves to HANDLER.
- HANDLER:
  - `eret` moves to RETURN and clears `exl` on the same edge.
  - `syscall` is ignored and sets `nest_err`.
  - Interrupts are not taken.
- RETURN lasts exactly one cycle with `ret_req`=1, then moves to RUN.
  - A take condition present during RETURN is deferred to RUN; it is never lost.
- `eret` in RUN, ENTER or RETURN is ignored.
- `cause_ip` = `pending & im`, combinational.

## Timing
- Event sampled at edge N → `exc_req` high throughout cycle N+1, with `epc`, `exl` and `cause_code` already updated.
- `eret` sampled at edge M → `ret_req` high in cycle M+1, with `exl`=0 and `epc` unchanged.
- Minimum spacing is four cycles take-to-take: ENTER, HANDLER (at least one cycle), RETURN, RUN.
- Asynchronous reset mid-ENTER or mid-RETURN:
  - the strobe drops immediately;
  - the state returns to RUN;
  - all captured values are cleared.

## Configuration
- `IRQ_EDGE_EN` defined:
  - Pending bits latch on the rising edge of each `irq[i]`, using a one-cycle delayed copy of `irq`.
  - On interrupt take, only the highest-index bit of `pending & im` is cleared.
  - A new rising edge on the same bit in the same cycle keeps the bit set.
- `IRQ_EDGE_EN` undefined:
  - Pending = `irq`, level-sensitive, with no storage.
  - The handler must quiet the source before `eret`.

## Structure
- Shared package `cp0_pkg` holds:
  - the state encoding;
  - cause codes `EXC_INT`=0 and `EXC_SYS`=8;
  - the default `EXC_VECTOR`.
- One sub-module, `irq_pending`: edge/level capture, mask register and `cause_ip` generation.
- All other logic (FSM, EPC/cause registers) lives in the top module.

## Test plan
- Reset: hold `reset_n`=0 with `irq`=8'hFF → all outputs 0 and the state is RUN; release → no `exc_req` while `im`=0.
- Interrupt: `im`=8'h04, `ie`=1, raise `irq[2]` with `pc_next`=32'h0040_0010 → one cycle later `exc_req`=1 for exactly one cycle, `epc`=32'h0040_0010, `exl`=1, `cause_code`=0.
- Syscall priority: `syscall`=1 and an enabled pending `irq[0]` in the same cycle → `cause_code`=8; after `eret` and RETURN, the interrupt is taken with `cause_code`=0.
- Return: `eret` in HANDLER with `epc`=32'h0040_0010 → next cycle `ret_req`=1, `epc`=32'h0040_0010, `exl`=0; `eret` pulsed in RUN → no `ret_req`.
- Nesting: `syscall` while `exl`=1 → no `exc_req`, `epc` unchanged, `nest_err`=1 until reset.
- `IRQ_EDGE_EN` build: 1-cycle pulse on `irq[5]` with `ie`=0, then `ie`=1 → entry occurs, pending bit 5 clears. Level build: the same pulse is lost.
